axis_text_framer: RTL
=====================

// Module: axis_text_framer
// PURPOSE
//  Receives text from an AXI4-Stream byte interface and assembles it into the
//  4-row x 16-col character frame driven onto the OLED screen controller's
//  str1..str4 inputs. One AXIS packet (tlast-terminated) is one screen frame.
//  Outputs update atomically on frame commit and are never seen half-written.
// PARAMETERS
//  ROWS      4      text rows, fixed by the OLED character grid
//  COLS      16     characters per row; each row output is COLS*8 bits
//  PAD_CHAR  8'h20  fill for unwritten cells (space)
//  SUB_CHAR  8'h3F  replaces non-printable bytes ('?')
// PORTS
//  clk            in   1    system clock
//  rst            in   1    asynchronous, active-high reset
//  s_axis_tdata   in   8    ASCII byte
//  s_axis_tvalid  in   1    byte valid
//  s_axis_tready  out  1    framer can accept a byte
//  s_axis_tlast   in   1    last byte of frame; triggers commit
//  str1..str4     out  128  row 0..3 text; column 0 in bits [127:120], column 15 in [7:0]
//  frame_valid    out  1    1-cycle pulse when str1..str4 are updated
//  overflow       out  1    committed frame dropped >=1 byte; held until next commit
//  frame_count    out  16   committed frames, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release): str1..str4 all PAD_CHAR, frame_valid=0,
//   overflow=0, frame_count=0, s_axis_tready=0. Staging buffer is all PAD_CHAR,
//   row=0, col=0, drop=0, state=FILL. tready=1 from the first cycle after release.
//  States: FILL (tready=1), COMMIT (tready=0, exactly 1 cycle).
//  A byte is accepted on a clk edge with tvalid&tready. In FILL, per accepted byte:
//   - 0x0D: discarded; no cell written; no overflow.
//   - 0x0A: if row<3: row++, col=0. If row==3: set full; no overflow.
//   - other: a byte <0x20 or >0x7E is replaced by SUB_CHAR. If col==16 (pending
//     wrap) and row<3: row++, col=0 first. The byte is written to staging[row][col],
//     then col++. If full, or row==3 with col==16, the byte is dropped and drop=1.
//   - col is 5 bits (0..16). 16 means the row is complete and wrap is pending.
//     0x0A at col==16 advances exactly one row and never leaves a blank row.
//   - tlast applies after the byte is processed, whatever the byte class
//     (including 0x0D, 0x0A or a dropped byte). Next state is COMMIT.
//  COMMIT (cycle after the tlast beat):
//   - At the closing edge: str1..str4 <= staging, overflow <= drop,
//     frame_count++. Staging <= PAD_CHAR, row/col/full/drop <= 0. State <= FILL.
//   - frame_valid is high for the single cycle following that edge.
//   - Latency: tlast beat at edge N -> outputs valid after edge N+1, tready=0
//     between N and N+1 (one bubble per frame).
//  Cells not written in a frame show PAD_CHAR. The previous frame never persists.
//  tvalid low with tready high: no state change. Beats with tvalid=0 are ignored.
//  Reset mid-frame: the partial frame is discarded. Outputs return to reset values.
// STRUCTURE
//  Shared header display_defs.vh: ROWS, COLS, PAD_CHAR, SUB_CHAR,
//   ASCII_LF=8'h0A, ASCII_CR=8'h0D, PRINT_MIN=8'h20, PRINT_MAX=8'h7E.
//  No sub-module. Byte sanitising is a local function.
//  Staging is 4 x 128-bit registers with a byte-lane write enable decoded from {row,col[3:0]}.
// TESTING
//  1 "HELLO",tlast on 'O' -> str1=48454C4C4F followed by 11x20; str2..4 all 20;
//    frame_valid 1 cycle; frame_count=1.
//  2 64 bytes 'A'..,tlast on 64th -> rows 0..3 each hold 16 chars in order; overflow=0.
//  3 16 x 'X' then 0x0A then 'Y',tlast -> str1=16x58, str2[127:120]=59; no blank row.
//  4 70 bytes,tlast on 70th -> last 6 dropped; overflow=1; next clean frame -> overflow=0.
//  5 "A",0x0D,0x01,0x0A,"B",tlast -> str1 starts 41 3F then 20s; str2 starts 42.
//  6 assert rst mid-frame after 10 bytes -> all outputs reset immediately; the next
//    frame "Z",tlast -> str1 starts 5A with no remnants. Also back-to-back frames
//    with tvalid held high -> tready=0 for exactly 1 cycle per frame.

Source files
------------

// File: rtl/axis_text_framer_pkg.sv
// Shared constants, state encoding for the OLED text framer.
package axis_text_framer_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 16;

  localparam logic [7:0] PAD_CHAR  = 8'h20;
  localparam logic [7:0] SUB_CHAR  = 8'h3F;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/axis_text_framer_if.sv
// AXI4-Stream byte channel carrying text into the framer.
interface axis_text_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_text_framer.sv
// Assembles one tlast-terminated AXIS packet into a 4x16 character frame and
// publishes all four rows at once on commit.
module axis_text_framer
  import axis_text_framer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  axis_text_framer_if.slave    s_axis,
  output logic [COLS*8-1:0]    str1,
  output logic [COLS*8-1:0]    str2,
  output logic [COLS*8-1:0]    str3,
  output logic [COLS*8-1:0]    str4,
  output logic                 frame_valid,
  output logic                 overflow,
  output logic [15:0]          frame_count
);

  // Non-printable bytes become SUB_CHAR so the glyph ROM is never indexed out of range.
  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return (b < PRINT_MIN || b > PRINT_MAX) ? SUB_CHAR : b;
  endfunction

  state_t                          state;
  logic                            tready_q;
  logic [ROWS-1:0][COLS*8-1:0]     staging;
  logic [1:0]                      row;
  logic [4:0]                      col;   // 16 = row complete, wrap pending
  logic                            full;
  logic                            drop;

  logic                            acc;
  logic [7:0]                      ch;
  logic                            wr_en;
  logic [1:0]                      wr_row;
  logic [3:0]                      wr_col;
  logic [1:0]                      nrow;
  logic [4:0]                      ncol;
  logic                            nfull;
  logic                            ndrop;
  logic [ROWS-1:0][COLS-1:0]       lane_we;

  assign s_axis.tready = tready_q;
  assign acc           = s_axis.tvalid & tready_q & (state == FILL);
  assign ch            = sanitize(s_axis.tdata);

  // Cursor update and write address for the byte accepted this cycle.
  always_comb begin
    nrow   = row;
    ncol   = col;
    nfull  = full;
    ndrop  = drop;
    wr_en  = 1'b0;
    wr_row = row;
    wr_col = col[3:0];
    if (acc) begin
      if (s_axis.tdata == ASCII_CR) begin
        // carriage return carries no content
      end else if (s_axis.tdata == ASCII_LF) begin
        if (row != 2'(ROWS-1)) begin
          nrow = row + 2'd1;
          ncol = 5'd0;
        end else begin
          nfull = 1'b1;
        end
      end else if (full || (row == 2'(ROWS-1) && col == 5'(COLS))) begin
        ndrop = 1'b1;
      end else begin
        // a pending wrap is resolved only when a printable byte arrives,
        // so LF right after a full row never leaves a blank row
        if (col == 5'(COLS)) begin
          wr_row = row + 2'd1;
          wr_col = 4'd0;
        end
        wr_en = 1'b1;
        nrow  = wr_row;
        ncol  = {1'b0, wr_col} + 5'd1;
      end
    end
  end

  // One-hot byte-lane enable from {row, col}.
  always_comb begin
    lane_we = '0;
    if (wr_en) lane_we[wr_row][wr_col] = 1'b1;
  end

  // Frame FSM: fill staging in FILL, publish and clear it in the one-cycle COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      tready_q    <= 1'b0;
      staging     <= {(ROWS*COLS){PAD_CHAR}};
      row         <= 2'd0;
      col         <= 5'd0;
      full        <= 1'b0;
      drop        <= 1'b0;
      str1        <= {COLS{PAD_CHAR}};
      str2        <= {COLS{PAD_CHAR}};
      str3        <= {COLS{PAD_CHAR}};
      str4        <= {COLS{PAD_CHAR}};
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      case (state)
        FILL: begin
          frame_valid <= 1'b0;
          tready_q    <= 1'b1;
          if (acc) begin
            row  <= nrow;
            col  <= ncol;
            full <= nfull;
            drop <= ndrop;
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                if (lane_we[r][c]) staging[r][(COLS-1-c)*8 +: 8] <= ch;
            if (s_axis.tlast) begin
              state    <= COMMIT;
              tready_q <= 1'b0;
            end
          end
        end
        COMMIT: begin
          str1        <= staging[0];
          str2        <= staging[1];
          str3        <= staging[2];
          str4        <= staging[3];
          overflow    <= drop;
          frame_count <= frame_count + 16'd1;
          frame_valid <= 1'b1;
          staging     <= {(ROWS*COLS){PAD_CHAR}};
          row         <= 2'd0;
          col         <= 5'd0;
          full        <= 1'b0;
          drop        <= 1'b0;
          tready_q    <= 1'b1;
          state       <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
